// File: rtl/card_draw_arbiter.sv
// Arbitrates three draw requesters onto one card generator and tracks a
// finite shoe, redrawing exhausted ranks and refilling when empty.
module card_draw_arbiter #(
    parameter int NUM_DECKS = 1,
    parameter int GEN_LAT   = 2,
    parameter int MAX_RETRY = 7,
    parameter int LOW_TH    = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       shuffle,
    input  logic [3:0] gen_card,
    output logic       gen_on,
    output logic [2:0] grant,
    output logic       card_valid,
    output logic [3:0] card,
    output logic       shuffle_done,
    output logic       low_shoe,
    output logic [7:0] cards_left,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, SHUF, FIRE, WAIT, CHECK, DELIVER
    } state_t;

    localparam logic [6:0] RANK_FULL = 7'(4 * NUM_DECKS);
    localparam logic [6:0] TEN_FULL  = 7'(16 * NUM_DECKS);
    localparam logic [7:0] SHOE_FULL = 8'(52 * NUM_DECKS);

    state_t     state, state_nx;
    logic [6:0] cnt [1:10];
    logic [7:0] left_q;
    logic [2:0] grant_q, grant_nx;
    logic [1:0] ptr, ptr_nx;
    logic [3:0] card_q, card_nx;
    logic [3:0] wait_cnt, wait_nx;
    logic [3:0] retry, retry_nx;
    logic       done_q;
    logic       refill, take;

    logic [6:0] gen_rank_cnt;
    logic [3:0] fallback;
    logic       gen_ok;
    logic [2:0] rot;
    logic [1:0] off, pick;

    // Count left for the generated rank, and lowest nonempty rank.
    always_comb begin
        gen_rank_cnt = '0;
        fallback     = '0;
        for (int i = 1; i <= 10; i++) begin
            if (gen_card == 4'(i))
                gen_rank_cnt = cnt[i];
        end
        for (int i = 10; i >= 1; i--) begin
            if (cnt[i] != '0)
                fallback = 4'(i);
        end
    end

    assign gen_ok = (gen_card >= 4'd1) && (gen_card <= 4'd10)
                 && (gen_rank_cnt != '0);

    // Rotate req so the pointer position becomes bit 0.
    always_comb begin
        unique case (ptr)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else             off = 2'd2;
        pick = 2'((int'(ptr) + int'(off)) % 3);
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_q;
        ptr_nx   = ptr;
        card_nx  = card_q;
        wait_nx  = wait_cnt;
        retry_nx = retry;
        refill   = 1'b0;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (shuffle) begin
                    state_nx = SHUF;
                end else if (|req) begin
                    if (left_q == '0) begin
                        state_nx = SHUF;
                    end else begin
                        state_nx = FIRE;
                        grant_nx = 3'(3'b001 << pick);
                        ptr_nx   = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    end
                end
            end
            SHUF: begin
                refill   = 1'b1;
                state_nx = IDLE;
            end
            FIRE: begin
                wait_nx  = '0;
                state_nx = (GEN_LAT > 1) ? WAIT : CHECK;
            end
            WAIT: begin
                if (int'(wait_cnt) >= GEN_LAT - 2)
                    state_nx = CHECK;
                else
                    wait_nx = wait_cnt + 4'd1;
            end
            CHECK: begin
                if (gen_ok) begin
                    card_nx  = gen_card;
                    state_nx = DELIVER;
                end else begin
                    retry_nx = retry + 4'd1;
                    if (int'(retry) + 1 < MAX_RETRY) begin
                        state_nx = FIRE;
                    end else begin
                        card_nx  = fallback;
                        state_nx = DELIVER;
                    end
                end
            end
            DELIVER: begin
                take     = 1'b1;
                retry_nx = '0;
                grant_nx = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            ptr      <= '0;
            card_q   <= '0;
            wait_cnt <= '0;
            retry    <= '0;
            done_q   <= 1'b0;
            left_q   <= SHOE_FULL;
            for (int i = 1; i <= 9; i++)
                cnt[i] <= RANK_FULL;
            cnt[10] <= TEN_FULL;
        end else begin
            state    <= state_nx;
            grant_q  <= grant_nx;
            ptr      <= ptr_nx;
            card_q   <= card_nx;
            wait_cnt <= wait_nx;
            retry    <= retry_nx;
            done_q   <= (state == SHUF);
            if (refill) begin
                left_q <= SHOE_FULL;
                for (int i = 1; i <= 9; i++)
                    cnt[i] <= RANK_FULL;
                cnt[10] <= TEN_FULL;
            end else if (take) begin
                if (left_q != '0)
                    left_q <= left_q - 8'd1;
                for (int i = 1; i <= 10; i++) begin
                    if (card_q == 4'(i) && cnt[i] != '0)
                        cnt[i] <= cnt[i] - 7'd1;
                end
            end
        end
    end

    assign gen_on       = (state == FIRE);
    assign card_valid   = (state == DELIVER);
    assign busy         = (state != IDLE);
    assign grant        = grant_q;
    assign card         = card_q;
    assign shuffle_done = done_q;
    assign cards_left   = left_q;
    assign low_shoe     = int'(left_q) < LOW_TH;

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Directed bench for card_draw_arbiter with a queue-fed generator model
// that returns a scripted value GEN_LAT cycles after each gen_on.
module tb_card_draw_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = '0;
    logic       shuffle = 1'b0;
    logic [3:0] gen_card = 4'd0;
    logic       gen_on;
    logic [2:0] grant;
    logic       card_valid;
    logic [3:0] card;
    logic       shuffle_done;
    logic       low_shoe;
    logic [7:0] cards_left;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] gen_q [$];
    logic [3:0] gen_dflt = 4'd1;
    int         gen_cnt = 0;

    card_draw_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .shuffle      (shuffle),
        .gen_card     (gen_card),
        .gen_on       (gen_on),
        .grant        (grant),
        .card_valid   (card_valid),
        .card         (card),
        .shuffle_done (shuffle_done),
        .low_shoe     (low_shoe),
        .cards_left   (cards_left),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Generator: value appears on the edge after gen_on, so it is
    // stable GEN_LAT=2 cycles after the strobe.
    always @(posedge clk) begin
        if (gen_on) begin
            gen_cnt <= gen_cnt + 1;
            if (gen_q.size() > 0)
                gen_card <= gen_q.pop_front();
            else
                gen_card <= gen_dflt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        shuffle = 1'b0;
        gen_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (card_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gen_on, card_valid, shuffle_done, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000",
                     {gen_on, card_valid, shuffle_done, busy});
        end
        checks++;
        if (grant !== 3'b000 || card !== 4'd0) begin
            errors++;
            $display("FAIL reset_grant_card got %b/%0d want 000/0",
                     grant, card);
        end
        checks++;
        if (cards_left !== 8'd52 || low_shoe !== 1'b0) begin
            errors++;
            $display("FAIL reset_shoe got %0d/%b want 52/0",
                     cards_left, low_shoe);
        end
    endtask

    task automatic test_basic_draw();
        do_reset();
        gen_q.push_back(4'd7);
        req = 3'b010;
        tick();
        checks++;
        if (gen_on !== 1'b1 || grant !== 3'b010) begin
            errors++;
            $display("FAIL basic_fire got gen_on=%b grant=%b want 1/010",
                     gen_on, grant);
        end
        tick();
        checks++;
        if (gen_on !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_strobe got %b want 0", gen_on);
        end
        tick();
        tick();
        checks++;
        if (card_valid !== 1'b1 || card !== 4'd7 || grant !== 3'b010) begin
            errors++;
            $display("FAIL basic_deliver got v=%b card=%0d grant=%b want 1/7/010",
                     card_valid, card, grant);
        end
        req = '0;
        tick();
        checks++;
        if (cards_left !== 8'd51 || grant !== 3'b000 || card !== 4'd7) begin
            errors++;
            $display("FAIL basic_after got left=%0d grant=%b card=%0d want 51/000/7",
                     cards_left, grant, card);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4];
        bit ok;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        for (int k = 0; k < 4; k++)
            gen_q.push_back(4'(k + 2));
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok || grant !== exp_g[k] || card !== 4'(k + 2)) begin
                errors++;
                $display("FAIL rr_%0d got ok=%b grant=%b card=%0d want 1/%b/%0d",
                         k, ok, grant, card, exp_g[k], k + 2);
            end
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (cards_left !== 8'd48) begin
            errors++;
            $display("FAIL rr_left got %0d want 48", cards_left);
        end
    endtask

    task automatic test_exhausted();
        bit ok;
        int g0;
        logic [3:0] seqs [3][3];
        int lens [3];
        logic [3:0] exp_c [3];
        seqs = '{'{4'd1, 4'd5, 4'd0}, '{4'd0, 4'd12, 4'd6},
                 '{4'd1, 4'd8, 4'd0}};
        lens = '{2, 3, 2};
        exp_c = '{4'd5, 4'd6, 4'd8};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            gen_q.push_back(4'd1);
            req = 3'b001;
            wait_valid(ok);
            req = '0;
            checks++;
            if (!ok || card !== 4'd1) begin
                errors++;
                $display("FAIL ace_%0d got ok=%b card=%0d want 1/1",
                         k, ok, card);
            end
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < lens[s]; j++)
                gen_q.push_back(seqs[s][j]);
            g0 = gen_cnt;
            req = 3'b001;
            wait_valid(ok);
            req = '0;
            checks++;
            if (!ok || card !== exp_c[s] || gen_cnt - g0 != lens[s]) begin
                errors++;
                $display("FAIL redraw_%0d got ok=%b card=%0d gens=%0d want 1/%0d/%0d",
                         s, ok, card, gen_cnt - g0, exp_c[s], lens[s]);
            end
            tick();
        end
        checks++;
        if (cards_left !== 8'd45) begin
            errors++;
            $display("FAIL exhaust_left got %0d want 45", cards_left);
        end
    endtask

    task automatic test_fallback();
        bit ok;
        int g0;
        gen_q.delete();
        gen_dflt = 4'd1;
        g0 = gen_cnt;
        req = 3'b001;
        wait_valid(ok);
        req = '0;
        checks++;
        if (!ok || card !== 4'd2 || gen_cnt - g0 != 7) begin
            errors++;
            $display("FAIL fallback got ok=%b card=%0d gens=%0d want 1/2/7",
                     ok, card, gen_cnt - g0);
        end
        tick();
        checks++;
        if (cards_left !== 8'd44 || gen_cnt - g0 != 7) begin
            errors++;
            $display("FAIL fallback_after got left=%0d gens=%0d want 44/7",
                     cards_left, gen_cnt - g0);
        end
    endtask

    task automatic test_auto_refill();
        bit ok;
        int left;
        do_reset();
        for (int r = 1; r <= 10; r++)
            for (int n = 0; n < ((r == 10) ? 16 : 4); n++)
                gen_q.push_back(4'(r));
        for (int k = 1; k <= 52; k++) begin
            req = 3'b001;
            wait_valid(ok);
            req = '0;
            tick();
            left = 52 - k;
            checks++;
            if (!ok || int'(cards_left) != left
                || low_shoe !== (left < 15)) begin
                errors++;
                $display("FAIL drain_%0d got ok=%b left=%0d low=%b want 1/%0d/%b",
                         k, ok, cards_left, low_shoe, left, left < 15);
            end
        end
        gen_dflt = 4'd9;
        req = 3'b001;
        tick();
        checks++;
        if (busy !== 1'b1 || gen_on !== 1'b0) begin
            errors++;
            $display("FAIL refill_shuf got busy=%b gen_on=%b want 1/0",
                     busy, gen_on);
        end
        tick();
        checks++;
        if (shuffle_done !== 1'b1 || cards_left !== 8'd52) begin
            errors++;
            $display("FAIL refill_done got done=%b left=%0d want 1/52",
                     shuffle_done, cards_left);
        end
        tick();
        checks++;
        if (gen_on !== 1'b1 || shuffle_done !== 1'b0) begin
            errors++;
            $display("FAIL refill_fire got gen_on=%b done=%b want 1/0",
                     gen_on, shuffle_done);
        end
        tick();
        tick();
        tick();
        checks++;
        if (card_valid !== 1'b1 || card !== 4'd9) begin
            errors++;
            $display("FAIL refill_card got v=%b card=%0d want 1/9",
                     card_valid, card);
        end
        req = '0;
        tick();
        checks++;
        if (cards_left !== 8'd51) begin
            errors++;
            $display("FAIL refill_left got %0d want 51", cards_left);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        gen_dflt = 4'd3;
        req = 3'b001;
        tick();
        tick();
        reset = 1'b1;
        req = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== 3'b000 || card_valid !== 1'b0
            || cards_left !== 8'd52 || card !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b grant=%b v=%b left=%0d card=%0d",
                     busy, grant, card_valid, cards_left, card);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (card_valid)
                seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_abort got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_shuffle();
        bit ok;
        gen_dflt = 4'd4;
        req = 3'b100;
        wait_valid(ok);
        req = '0;
        tick();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        checks++;
        if (busy !== 1'b1 || cards_left !== 8'd51) begin
            errors++;
            $display("FAIL shuf_start got busy=%b left=%0d want 1/51",
                     busy, cards_left);
        end
        tick();
        checks++;
        if (shuffle_done !== 1'b1 || cards_left !== 8'd52 || busy !== 1'b0) begin
            errors++;
            $display("FAIL shuf_done got done=%b left=%0d busy=%b want 1/52/0",
                     shuffle_done, cards_left, busy);
        end
        req = 3'b001;
        tick();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        wait_valid(ok);
        req = '0;
        tick();
        tick();
        tick();
        checks++;
        if (!ok || cards_left !== 8'd51 || busy !== 1'b0) begin
            errors++;
            $display("FAIL shuf_busy_ignored got ok=%b left=%0d busy=%b want 1/51/0",
                     ok, cards_left, busy);
        end
        shuffle = 1'b1;
        req = 3'b001;
        tick();
        shuffle = 1'b0;
        checks++;
        if (gen_on !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL shuf_priority got gen_on=%b busy=%b want 0/1",
                     gen_on, busy);
        end
        tick();
        tick();
        checks++;
        if (gen_on !== 1'b1 || cards_left !== 8'd52) begin
            errors++;
            $display("FAIL shuf_then_req got gen_on=%b left=%0d want 1/52",
                     gen_on, cards_left);
        end
        wait_valid(ok);
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_round_robin();
        test_exhausted();
        test_fallback();
        test_auto_refill();
        test_reset_mid();
        test_shuffle();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
